top_aes_dec: RTL and testbench

//  AES-128 decryption top: accepts ciphertext + ROM key index, fetches key from ROM_key,

---
 rtl/top_aes_dec.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_top_aes_dec.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/top_aes_dec.sv
// top_aes_dec -- AES-128 single-block decryption top.
//   Accepts a ciphertext block and a key index. It reads the key from the on-chip
//   key ROM, expands the key in aes_core, and decrypts one block. The plaintext is
//   then presented with a one-cycle done pulse.
//   Optional feature macro: AES_DEC_KEY_CACHE_EN. When it is defined, the top skips
//   the ROM read and key expansion if the last expanded key index is requested again.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset (aborts any operation, no done)
//   start       request, sampled only in IDLE
//   key_addr    ROM key index, captured with start
//   ciphertext  block to decrypt, captured with start
//   busy        high in every state except IDLE
//   done        one-cycle pulse; result is valid in that cycle and is held after it
//   result      registered plaintext
// Sub-modules in this file:
//   ROM_key   -- 32 x 128-bit key ROM with a synchronous read.
//   aes_core  -- iterative AES-128 key expansion (ready) and inverse cipher (result_valid).

module ROM_key #(
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [addr_width-1:0] addr,
  output logic [127:0]          data
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (en) begin
      case (addr)
        addr_width'(0): data <= 128'h000102030405060708090a0b0c0d0e0f;
        addr_width'(1): data <= 128'h2b7e151628aed2a6abf7158809cf4f3c;
        default:        data <= {{(128-addr_width){1'b0}}, addr};
      endcase
    end
  end
endmodule

module aes_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic [127:0] key,
  input  logic [127:0] block,
  output logic         ready,
  output logic         result_valid,
  output logic [127:0] result
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) is computed as a^254 (which maps 0 to 0).
  // This replaces the usual 256-entry S-box tables.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = ginv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte j of the state is bits [127-8j -: 8], in column-major order (j = 4*col + row).
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] rk [0:10];
  logic [3:0]   kx_idx;
  logic [7:0]   rcon;
  logic         kx_run;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         dec_run;

  // Expansion produces one round key per cycle (10 cycles). Decryption runs one
  // round per cycle (10 cycles, after the whitening load). All round keys stay
  // stored, so further blocks can reuse them without another init.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 11; i++) rk[i] <= '0;
      kx_idx       <= '0;
      rcon         <= '0;
      kx_run       <= 1'b0;
      ready        <= 1'b1;
      st           <= '0;
      rnd          <= '0;
      dec_run      <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      if (init) begin
        rk[0]  <= key;
        kx_idx <= 4'd1;
        rcon   <= 8'h01;
        kx_run <= 1'b1;
        ready  <= 1'b0;
      end else if (kx_run) begin
        rk[kx_idx] <= next_rk(rk[kx_idx - 4'd1], rcon);
        rcon       <= xtime(rcon);
        kx_idx     <= kx_idx + 4'd1;
        if (kx_idx == 4'd10) begin
          kx_run <= 1'b0;
          ready  <= 1'b1;
        end
      end

      if (next) begin
        st           <= block ^ rk[10];
        rnd          <= 4'd9;
        dec_run      <= 1'b1;
        result_valid <= 1'b0;
      end else if (dec_run) begin
        if (rnd != 4'd0) begin
          st  <= inv_mix(inv_shift_sub(st) ^ rk[rnd]);
          rnd <= rnd - 4'd1;
        end else begin
          result       <= inv_shift_sub(st) ^ rk[0];
          dec_run      <= 1'b0;
          result_valid <= 1'b1;
        end
      end
    end
  end
endmodule

module top_aes_dec #(
  parameter int unsigned aes_len    = 128,
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] key_addr,
  input  logic [aes_len-1:0]    ciphertext,
  output logic                  busy,
  output logic                  done,
  output logic [aes_len-1:0]    result
);
  typedef enum logic [2:0] {IDLE, KEY_RD, INIT, WAIT_KEY, NEXT, WAIT_RES, DONE} state_t;

  state_t                state_q, state_d;
  logic [aes_len-1:0]    ct_q;
  logic [addr_width-1:0] addr_q;
  logic [aes_len-1:0]    result_q;
  logic                  wait_first_q;
  logic                  rst_n;
  logic                  rom_en, core_init, core_next;
  logic [127:0]          rom_data, core_result;
  logic                  core_ready, core_valid;
  logic                  cache_hit;

  assign rst_n = ~rst;

  ROM_key #(.addr_width(addr_width)) u_rom (
    .clk     (clk),
    .reset_n (rst_n),
    .en      (rom_en),
    .addr    (addr_q),
    .data    (rom_data)
  );

  // Only 128-bit keys are supported, so the lower half of the {rom_data, 128'b0}
  // key word is never carried into the core. The ROM output register holds the
  // key for the whole operation.
  aes_core u_core (
    .clk          (clk),
    .reset_n      (rst_n),
    .init         (core_init),
    .next         (core_next),
    .key          (rom_data),
    .block        (ct_q),
    .ready        (core_ready),
    .result_valid (core_valid),
    .result       (core_result)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic                  cache_valid_q;
  logic [addr_width-1:0] cache_addr_q;

  // The round keys of the last expansion stay in the core. A repeated key index
  // can therefore go straight to decryption.
  assign cache_hit = cache_valid_q && (key_addr == cache_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
    end else if (state_q == WAIT_KEY && state_d == NEXT) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= addr_q;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rom_en    = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = cache_hit ? NEXT : KEY_RD;
      KEY_RD:   begin rom_en = 1'b1; state_d = INIT; end
      INIT:     begin core_init = 1'b1; state_d = WAIT_KEY; end
      // Core flags only drop one cycle after init/next, so the first wait cycle is ignored.
      WAIT_KEY: if (!wait_first_q && core_ready) state_d = NEXT;
      NEXT:     begin core_next = 1'b1; state_d = WAIT_RES; end
      WAIT_RES: if (!wait_first_q && core_valid) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_first_q <= 1'b0;
      ct_q         <= '0;
      addr_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= (state_d != state_q);
      if (state_q == IDLE && start) begin
        ct_q   <= ciphertext;
        addr_q <= key_addr;
      end
      // Load the result on entry to DONE, so it is already valid during the done pulse.
      if (state_q == WAIT_RES && state_d == DONE) result_q <= core_result;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule

// File: tb/tb_top_aes_dec.sv
module tb_top_aes_dec;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   key_addr = '0;
  logic [127:0] ciphertext = '0;
  logic         busy, done;
  logic [127:0] result;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;

  top_aes_dec #(.aes_len(128), .addr_width(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_addr   (key_addr),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  int unsigned  tests = 0;
  int unsigned  fails = 0;
  int unsigned  done_cnt = 0;
  int unsigned  init_cnt = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected plaintext.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.core_init) init_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 result %h, expected no done", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [4:0] a, input logic [127:0] ct);
    @(negedge clk);
    key_addr   = a;
    ciphertext = ct;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int unsigned lat);
    int unsigned base;
    base = done_cnt;
    lat  = 0;
    while (done_cnt == base && lat < 300) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (done_cnt == base) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected a done pulse", name, lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned l1, l2, i0, d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_result", result, '0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 vector
    exp_q.push_back(PT1);
    issue(5'd0, CT1);
    wait_done("t1", l1);
    @(negedge clk);
    #1;
    check("t1_busy_after", 128'(busy), 128'd0);
    check("t1_result_held", result, PT1);

    // SP800-38A vector
    exp_q.push_back(PT2);
    issue(5'd1, CT2);
    wait_done("t2", l1);

    // start held and re-pulsed while busy, inputs changed mid-operation
    d0 = done_cnt;
    exp_q.push_back(PT1);
    @(negedge clk);
    key_addr   = 5'd0;
    ciphertext = CT1;
    start      = 1'b1;
    repeat (8) begin
      @(negedge clk);
      ciphertext = ~ciphertext;
      key_addr   = 5'd1;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    start      = 1'b1;
    ciphertext = CT2;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", l1);
    repeat (5) @(negedge clk);
    #1;
    check("t3_single_done", 128'(done_cnt - d0), 128'd1);

    // reset while the decryption rounds are running
    issue(5'd1, CT2);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 128'(busy), 128'd0);
    check("t4_rst_done", 128'(done), 128'd0);
    check("t4_rst_result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(PT1);
    issue(5'd0, CT1);
    wait_done("t4_repeat", l1);

    // same key twice back-to-back, then a different key
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i0 = init_cnt;
    exp_q.push_back(PT1);
    issue(5'd0, CT1);
    wait_done("t5_first", l1);
    check("t5_first_init", 128'(init_cnt - i0), 128'd1);
    i0 = init_cnt;
    exp_q.push_back(PT1);
    issue(5'd0, CT1);
    wait_done("t5_second", l2);
`ifdef AES_DEC_KEY_CACHE_EN
    check("t5_second_init", 128'(init_cnt - i0), 128'd0);
    check("t5_latency_gap", 128'((l1 >= l2 + 13) ? 1 : 0), 128'd1);
`else
    check("t6_second_init", 128'(init_cnt - i0), 128'd1);
    check("t6_latency_same", 128'(l2), 128'(l1));
`endif
    i0 = init_cnt;
    exp_q.push_back(PT2);
    issue(5'd1, CT2);
    wait_done("t5_key1", l1);
    check("t5_key1_init", 128'(init_cnt - i0), 128'd1);

    repeat (5) @(negedge clk);
    #1;
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    check("final_busy", 128'(busy), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
